// File: rtl/counter_scheduler_if.sv
// Host-side bundle for counter_scheduler: trigger/wire-in requests toward the
// scheduler, counter value, pending flags and boundary events back to the host.
interface counter_scheduler_if #(
    parameter int unsigned DIV_W = 24
);
    logic [DIV_W-1:0] cfg_div;
    logic             auto_en;
    logic             hold;
    logic             trig_clear;
    logic             trig_load;
    logic             trig_up;
    logic             trig_down;
    logic [7:0]       load_value;
    logic [7:0]       count;
    logic [4:0]       pending;
    logic             evt_zero;
    logic             evt_max;
    logic             evt_wrap;
    logic [7:0]       drop_count;

    modport master (
        output cfg_div, auto_en, hold,
        output trig_clear, trig_load, trig_up, trig_down, load_value,
        input  count, pending, evt_zero, evt_max, evt_wrap, drop_count
    );

    modport slave (
        input  cfg_div, auto_en, hold,
        input  trig_clear, trig_load, trig_up, trig_down, load_value,
        output count, pending, evt_zero, evt_max, evt_wrap, drop_count
    );
endinterface

// File: rtl/counter_scheduler.sv
// Serialises clear/load/up/down/auto-tick requests onto one 8-bit counter.
// Define COUNTER_SCHEDULER_SAT_EN for saturating (blocked-at-boundary) arithmetic.
module counter_scheduler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic          clk,
    input  logic          reset,
    counter_scheduler_if.slave bus
);

    typedef struct packed {
        logic tick;
        logic down;
        logic up;
        logic load;
        logic clear;
    } req_t;

    typedef enum logic [1:0] {
        RR_UP   = 2'd0,
        RR_DOWN = 2'd1,
        RR_TICK = 2'd2
    } rr_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_UP    = 3'd3,
        OP_DOWN  = 3'd4,
        OP_TICK  = 3'd5
    } op_e;

    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick_req;
    req_t             req, pend_q, pend_d, gnt;
    rr_e              rr_q, rr_d;
    op_e              op;
    logic [7:0]       count_q, count_d;
    logic [7:0]       drop_q, drop_d;
    logic [4:0]       drop_vec;
    logic [2:0]       n_drop;
    logic [8:0]       drop_sum;
    logic             blocked;
    logic             zero_q, zero_d, max_q, max_d, wrap_q, wrap_d;

    function automatic op_e rr_pick(input logic up, input logic down,
                                    input logic tick, input rr_e ptr);
        rr_pick = OP_NONE;
        unique case (ptr)
            RR_UP: begin
                if (up)        rr_pick = OP_UP;
                else if (down) rr_pick = OP_DOWN;
                else if (tick) rr_pick = OP_TICK;
            end
            RR_DOWN: begin
                if (down)      rr_pick = OP_DOWN;
                else if (tick) rr_pick = OP_TICK;
                else if (up)   rr_pick = OP_UP;
            end
            RR_TICK: begin
                if (tick)      rr_pick = OP_TICK;
                else if (up)   rr_pick = OP_UP;
                else if (down) rr_pick = OP_DOWN;
            end
            default: rr_pick = OP_NONE;
        endcase
    endfunction

    // Prescaler: parked at cfg_div while idle, so a new divisor lands on the next reload.
    always_comb begin
        tick_req = 1'b0;
        presc_d  = bus.cfg_div;
        if (bus.auto_en) begin
            if (presc_q == '0) begin
                tick_req = 1'b1;
            end else begin
                presc_d = presc_q - DIV_W'(1);
            end
        end
    end

    always_comb begin
        req.clear = bus.trig_clear;
        req.load  = bus.trig_load;
        req.up    = bus.trig_up;
        req.down  = bus.trig_down;
        req.tick  = tick_req;
    end

    always_comb begin
        op   = OP_NONE;
        rr_d = rr_q;
        if (pend_q.clear) begin
            op = OP_CLEAR;
        end else if (pend_q.load) begin
            op = OP_LOAD;
        end else if (!bus.hold) begin
            op = rr_pick(pend_q.up, pend_q.down, pend_q.tick, rr_q);
        end
        unique case (op)
            OP_UP:   rr_d = RR_DOWN;
            OP_DOWN: rr_d = RR_TICK;
            OP_TICK: rr_d = RR_UP;
            default: rr_d = rr_q;
        endcase
    end

    always_comb begin
        gnt.clear = (op == OP_CLEAR);
        gnt.load  = (op == OP_LOAD);
        gnt.up    = (op == OP_UP);
        gnt.down  = (op == OP_DOWN);
        gnt.tick  = (op == OP_TICK);
    end

    // A pulse arriving while its own bit is being granted simply re-arms the bit.
    always_comb begin
        pend_d   = (pend_q & ~gnt) | req;
        drop_vec = req & pend_q & ~gnt;
        n_drop   = 3'($countones(drop_vec));
        drop_sum = {1'b0, drop_q} + {6'd0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (op == OP_CLEAR) begin
            drop_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        blocked = 1'b0;
        wrap_d  = 1'b0;
        zero_d  = 1'b0;
        max_d   = 1'b0;
        unique case (op)
            OP_CLEAR: count_d = '0;
            OP_LOAD:  count_d = bus.load_value;
            OP_UP, OP_TICK: begin
                if (count_q == '1) begin
                    wrap_d = 1'b1;
`ifdef COUNTER_SCHEDULER_SAT_EN
                    blocked = 1'b1;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            OP_DOWN: begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
`ifdef COUNTER_SCHEDULER_SAT_EN
                    blocked = 1'b1;
`else
                    count_d = '1;
`endif
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            default: count_d = count_q;
        endcase
        if (op != OP_NONE && !blocked) begin
            zero_d = (count_d == '0);
            max_d  = (count_d == '1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            pend_q  <= '0;
            rr_q    <= RR_UP;
            count_q <= '0;
            drop_q  <= '0;
            zero_q  <= 1'b0;
            max_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            zero_q  <= zero_d;
            max_q   <= max_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.pending    = pend_q;
    assign bus.evt_zero   = zero_q;
    assign bus.evt_max    = max_q;
    assign bus.evt_wrap   = wrap_q;
    assign bus.drop_count = drop_q;

endmodule
